// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the external SRAM controller.
// State encodings, default address map and pad width.
package sram_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
   localparam int          SRAM_DW           = 16;
   localparam int          CNT_W             = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with zero flag.
// Shared by multi-cycle peripherals to time access phases.
module sram_wait_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// Sequences 32-bit loads/stores onto a 16-bit async SRAM
// as a low then high half-word phase.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          WAIT_CYCLES = 2,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t             state;
   logic               op_write;
   logic [SRAM_AW-2:0] word_q;
   logic [31:0]        wdata_q;
   logic [31:0]        offset;
   logic [SRAM_AW-2:0] word;
   logic               unused_bits;
   logic               req;
   logic               busy;
   logic               cnt_load;
   logic               cnt_zero;
   logic [CNT_W-1:0]   count_unused;

   assign req         = mem_read | mem_write;
   assign offset      = address - BASE_ADDR;
   assign word        = offset[SRAM_AW:2];
   assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
   assign busy        = (state == ST_LOW) || (state == ST_HIGH);

   assign cnt_load = ((state == ST_IDLE) && req) ||
                     ((state == ST_LOW) && cnt_zero);

   sram_wait_counter #(
      .W (CNT_W)
   ) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (RELOAD),
      .dec      (busy),
      .count    (count_unused),
      .zero     (cnt_zero)
   );

   // A simultaneous read and write request resolves to a read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_write  <= 1'b0;
         word_q    <= '0;
         wdata_q   <= '0;
         read_data <= '0;
         sram_addr <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  op_write  <= ~mem_read;
                  word_q    <= word;
                  wdata_q   <= write_data;
                  sram_addr <= {word, 1'b0};
                  state     <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (cnt_zero) begin
                  if (!op_write) read_data[15:0] <= sram_dq_in;
                  sram_addr <= {word_q, 1'b1};
                  state     <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (cnt_zero) begin
                  if (!op_write) read_data[31:16] <= sram_dq_in;
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ready = 1'b0;
      unique case (state)
         ST_IDLE: ready = ~req;
         ST_LOW:  ready = 1'b0;
         ST_HIGH: ready = 1'b0;
         ST_DONE: ready = 1'b1;
      endcase
   end

   assign sram_we_n   = ~(busy & op_write);
   assign sram_oe_n   = ~(busy & ~op_write);
   assign sram_dq_oe  = busy & op_write;
   assign sram_dq_out = (state == ST_HIGH) ? wdata_q[31:16]
                                           : wdata_q[15:0];

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small SRAM model
// per instance (WAIT_CYCLES=2 and WAIT_CYCLES=1 builds).
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd0, wr0;
   logic [31:0] addr0, wd0;
   logic [31:0] rdata0;
   logic        ready0;
   logic [17:0] saddr0;
   logic [15:0] dq_out0, dq_in0;
   logic        dq_oe0, we_n0, oe_n0;

   logic        rd1, wr1;
   logic [31:0] addr1, wd1;
   logic [31:0] rdata1;
   logic        ready1;
   logic [17:0] saddr1;
   logic [15:0] dq_out1, dq_in1;
   logic        dq_oe1, we_n1, oe_n1;

   logic [15:0] mem0 [16];
   logic [15:0] mem1 [16];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sram_controller #(
      .BASE_ADDR (32'd1024), .WAIT_CYCLES (2), .SRAM_AW (18)
   ) dut (
      .clk (clk), .rst (rst),
      .mem_read (rd0), .mem_write (wr0),
      .address (addr0), .write_data (wd0),
      .read_data (rdata0), .ready (ready0),
      .sram_addr (saddr0), .sram_dq_out (dq_out0),
      .sram_dq_oe (dq_oe0), .sram_dq_in (dq_in0),
      .sram_we_n (we_n0), .sram_oe_n (oe_n0)
   );

   sram_controller #(
      .BASE_ADDR (32'd1024), .WAIT_CYCLES (1), .SRAM_AW (18)
   ) dut1 (
      .clk (clk), .rst (rst),
      .mem_read (rd1), .mem_write (wr1),
      .address (addr1), .write_data (wd1),
      .read_data (rdata1), .ready (ready1),
      .sram_addr (saddr1), .sram_dq_out (dq_out1),
      .sram_dq_oe (dq_oe1), .sram_dq_in (dq_in1),
      .sram_we_n (we_n1), .sram_oe_n (oe_n1)
   );

   // SRAM models: contents re-seeded on reset, writes on strobe.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            mem0[i] <= 16'h0;
            mem1[i] <= 16'h0;
         end
         mem0[2] <= 16'hAAAA;
         mem0[3] <= 16'h5555;
         mem0[4] <= 16'h1111;
         mem0[5] <= 16'h2222;
         mem1[0] <= 16'hCAFE;
         mem1[1] <= 16'hF00D;
      end else begin
         if (!we_n0 && dq_oe0) mem0[saddr0[3:0]] <= dq_out0;
         if (!we_n1 && dq_oe1) mem1[saddr1[3:0]] <= dq_out1;
      end
   end

   assign dq_in0 = mem0[saddr0[3:0]];
   assign dq_in1 = mem1[saddr1[3:0]];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rdy;
      logic        we_n;
      logic        oe_n;
      logic        dq_oe;
      logic [17:0] saddr;
      logic [15:0] dq;
      logic        chk_rd;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(
      logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
      logic rdy, logic we_n, logic oe_n, logic dq_oe,
      logic [17:0] sa, logic [15:0] dq,
      logic crd, logic [31:0] rdv);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
      v.rdy = rdy; v.we_n = we_n; v.oe_n = oe_n;
      v.dq_oe = dq_oe; v.saddr = sa; v.dq = dq;
      v.chk_rd = crd; v.rdata = rdv;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
   endtask

   localparam logic [31:0] WD = 32'h12345678;
   localparam logic [31:0] RV = 32'h5555AAAA;

   initial begin
      // write at 1024 (cycles 0..6), read at 1028 (cycles 0..6)
      tbl[0]  = mk(0, 1, 1024, WD, 0, 1, 1, 0, 0, 16'h0,    1, 0);
      tbl[1]  = mk(0, 1, 1024, WD, 0, 0, 1, 1, 0, 16'h5678, 0, 0);
      tbl[2]  = mk(0, 1, 1024, WD, 0, 0, 1, 1, 0, 16'h5678, 0, 0);
      tbl[3]  = mk(0, 1, 1024, WD, 0, 0, 1, 1, 1, 16'h1234, 0, 0);
      tbl[4]  = mk(0, 1, 1024, WD, 0, 0, 1, 1, 1, 16'h1234, 0, 0);
      tbl[5]  = mk(0, 1, 1024, WD, 1, 1, 1, 0, 1, 16'h0,    1, 0);
      tbl[6]  = mk(0, 0, 1024, WD, 1, 1, 1, 0, 1, 16'h0,    1, 0);
      tbl[7]  = mk(1, 0, 1028, 0,  0, 1, 1, 0, 1, 16'h0,    1, 0);
      tbl[8]  = mk(1, 0, 1028, 0,  0, 1, 0, 0, 2, 16'h0,    0, 0);
      tbl[9]  = mk(1, 0, 1028, 0,  0, 1, 0, 0, 2, 16'h0,    0, 0);
      tbl[10] = mk(1, 0, 1028, 0,  0, 1, 0, 0, 3, 16'h0,    0, 0);
      tbl[11] = mk(1, 0, 1028, 0,  0, 1, 0, 0, 3, 16'h0,    0, 0);
      tbl[12] = mk(1, 0, 1028, 0,  1, 1, 1, 0, 3, 16'h0,    1, RV);
      tbl[13] = mk(0, 0, 1028, 0,  1, 1, 1, 0, 3, 16'h0,    1, RV);

      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset ready", 32'(ready0), 32'd1);
      chk("reset we_n", 32'(we_n0), 32'd1);
      chk("reset oe_n", 32'(oe_n0), 32'd1);
      chk("reset dq_oe", 32'(dq_oe0), 32'd0);
      chk("reset sram_addr", 32'(saddr0), 32'd0);
      chk("reset read_data", rdata0, 32'd0);

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         rd0 = tbl[i].rd; wr0 = tbl[i].wr;
         addr0 = tbl[i].addr; wd0 = tbl[i].wdata;
         #1;
         chk($sformatf("vec%0d ready", i), 32'(ready0),
             32'(tbl[i].rdy));
         chk($sformatf("vec%0d we_n", i), 32'(we_n0),
             32'(tbl[i].we_n));
         chk($sformatf("vec%0d oe_n", i), 32'(oe_n0),
             32'(tbl[i].oe_n));
         chk($sformatf("vec%0d dq_oe", i), 32'(dq_oe0),
             32'(tbl[i].dq_oe));
         chk($sformatf("vec%0d sram_addr", i), 32'(saddr0),
             32'(tbl[i].saddr));
         if (tbl[i].dq_oe)
            chk($sformatf("vec%0d dq_out", i), 32'(dq_out0),
                32'(tbl[i].dq));
         if (tbl[i].chk_rd)
            chk($sformatf("vec%0d read_data", i), rdata0,
                tbl[i].rdata);
      end

      // idle: pads stay quiet
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         chk($sformatf("idle%0d ready", c), 32'(ready0), 32'd1);
         chk($sformatf("idle%0d we_n", c), 32'(we_n0), 32'd1);
         chk($sformatf("idle%0d oe_n", c), 32'(oe_n0), 32'd1);
         chk($sformatf("idle%0d dq_oe", c), 32'(dq_oe0), 32'd0);
      end

      // both requests -> read; then back-to-back read
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c < 6) begin
            rd0 = 1'b1; wr0 = 1'b1;
            addr0 = 32'd1032; wd0 = 32'hDEADBEEF;
         end else begin
            rd0 = 1'b1; wr0 = 1'b0;
            addr0 = 32'd1024; wd0 = 32'h0;
         end
         #1;
         chk($sformatf("b2b%0d ready", c), 32'(ready0),
             32'((c == 5) || (c == 11)));
         chk($sformatf("b2b%0d we_n", c), 32'(we_n0), 32'd1);
         if (c == 5)
            chk("both-req read_data", rdata0, 32'h22221111);
         if (c == 11)
            chk("b2b read_data", rdata0, 32'h12345678);
      end
      @(negedge clk);
      idle_inputs();

      // reset during HIGH phase of a write
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         wr0 = 1'b1; addr0 = 32'd1036; wd0 = 32'h0BADF00D;
         if (c == 3) rst = 1'b1;
         #1;
         if (c == 3) begin
            chk("mid high we_n", 32'(we_n0), 32'd0);
            chk("mid high sram_addr", 32'(saddr0), 32'd7);
            chk("mid high dq_out", 32'(dq_out0), 32'h0BAD);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      #1;
      chk("abort ready", 32'(ready0), 32'd1);
      chk("abort we_n", 32'(we_n0), 32'd1);
      chk("abort oe_n", 32'(oe_n0), 32'd1);
      chk("abort dq_oe", 32'(dq_oe0), 32'd0);
      chk("abort read_data", rdata0, 32'd0);
      chk("abort sram_addr", 32'(saddr0), 32'd0);

      // single-cycle phases
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         idle_inputs();
         rd1 = (c < 4); addr1 = 32'd1024;
         #1;
         chk($sformatf("w1 c%0d ready", c), 32'(ready1),
             32'((c == 3) || (c == 4)));
         if (c == 1) begin
            chk("w1 c1 oe_n", 32'(oe_n1), 32'd0);
            chk("w1 c1 sram_addr", 32'(saddr1), 32'd0);
         end
         if (c == 2) begin
            chk("w1 c2 sram_addr", 32'(saddr1), 32'd1);
            chk("w1 low half", 32'(rdata1[15:0]), 32'hCAFE);
            chk("w1 high half", 32'(rdata1[31:16]), 32'h0);
         end
         if (c == 3)
            chk("w1 read_data", rdata1, 32'hF00DCAFE);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the memory stage's 32-bit load/store requests onto an external 16-bit asynchronous SRAM.
- Each access is done as two half-word phases (low, then high), each lasting WAIT_CYCLES clocks.
- Holds `ready` low while an access is in flight; the pipeline-freeze logic uses `ready` to stall all stages.
- Request inputs come straight from the memory-stage copy of the decoded `mem_read`/`mem_write` controls.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM half-word 0.
- WAIT_CYCLES, 2: clocks per half-word phase. Legal range is 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset. Synchronous, active-high.
- mem_read  in  1  load request from the memory stage.
- mem_write  in  1  store request from the memory stage.
- address  in  32  byte address from the ALU result.
- write_data  in  32  store data (Rm value).
- read_data  out  32  load result. Valid when `ready` is high after a read.
- ready  out  1  low while busy. Freeze the pipeline when low.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to the pad.
- sram_dq_oe  out  1  pad output enable (1 = drive).
- sram_dq_in  in  16  read data from the pad.
- sram_we_n  out  1  write strobe, active-low.
- sram_oe_n  out  1  output enable, active-low.

Behaviour:
- States: IDLE, LOW, HIGH, DONE. Encoding is 2 bits.
- Reset (rst=1 at an edge):
  - state=IDLE, counter=0, latched op/addr/data=0, read_data=0.
  - Resulting outputs: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0.
  - Reset mid-access aborts the access. The strobe deasserts at that edge and no partial read_data update is kept.
- Address mapping:
  - offset = (address - BASE_ADDR), mod 2^32.
  - word = offset[SRAM_AW:2]; the two LSBs are ignored (no alignment check).
  - LOW phase drives sram_addr = {word,0}; HIGH phase drives {word,1}.
- IDLE:
  - ready = ~(mem_read | mem_write), combinational.
  - On a request at an edge: latch op, address and write_data; load counter = WAIT_CYCLES-1; go to LOW.
  - If both mem_read and mem_write are high, the access is a read.
- LOW / HIGH:
  - ready=0.
  - Write op: sram_we_n=0, sram_dq_oe=1, sram_oe_n=1. sram_dq_out = wdata[15:0] in LOW, wdata[31:16] in HIGH.
  - Read op: sram_we_n=1, sram_dq_oe=0, sram_oe_n=0.
  - Counter decrements each edge.
  - At the edge where counter==0:
    - If read, latch sram_dq_in into read_data[15:0] (LOW) or read_data[31:16] (HIGH).
    - LOW goes to HIGH with counter reloaded; HIGH goes to DONE.
- DONE:
  - ready=1, all SRAM strobes inactive. Always goes to IDLE next edge.
  - The requester's inputs may still be asserted in DONE; they are ignored.
  - The request seen in the following IDLE cycle belongs to the next instruction.
- Latency:
  - Request first seen in IDLE at cycle 0; ready rises in cycle 2*WAIT_CYCLES+1.
  - Back-to-back accesses therefore cost 2*WAIT_CYCLES+2 cycles each.
- read_data holds its last value through writes and idle cycles.
- SRAM outputs decode only from registered state, op and data. There is no combinational path from request inputs to the pads.
- sram_addr holds its last value while idle.

Decomposition:
- Shared package/constants header:
  - state encodings (ST_IDLE, ST_LOW, ST_HIGH, ST_DONE);
  - default BASE_ADDR;
  - SRAM data width 16.
- One natural sub-module: `sram_wait_counter`. It is a loadable down-counter with a zero flag, reused by any later multi-cycle peripheral.
- Everything else stays in `sram_controller`.

Test Plan:
1. Write, WAIT_CYCLES=2, mem_write=1, address=1024, write_data=0x12345678 at cycle 0:
   - cycles 1-2: sram_addr=0, dq_out=0x5678, we_n=0, dq_oe=1;
   - cycles 3-4: sram_addr=1, dq_out=0x1234;
   - ready=1 only in cycle 5.
2. Read, mem_read=1, address=1028, SRAM model returns 0xAAAA at addr 2 and 0x5555 at addr 3:
   - oe_n=0 in cycles 1-4, we_n=1 throughout;
   - read_data=0x5555AAAA with ready=1 in cycle 5.
3. Idle: no requests for 20 cycles -> ready=1, we_n=1, oe_n=1, dq_oe=0 every cycle.
4. Reset mid-access: rst=1 during the HIGH phase of a write -> at the next edge state=IDLE, we_n=1, dq_oe=0, read_data=0.
5. Both requests and back-to-back timing:
   - mem_read=mem_write=1 at address 1032 -> read cycle, no we_n pulse.
   - A second read issued in the cycle after DONE -> ready low again for 5 cycles; total 6 cycles per access.
6. WAIT_CYCLES=1 build: single-cycle phases -> ready in cycle 3; low half latched at end of cycle 1, high half at end of cycle 2.
